// File: rtl/vu_pkg.sv
// Shared types, default parameter values and the pricing rule for the vending unit.
package vu_pkg;

  localparam int unsigned NPROD_DEF      = 4;
  localparam int unsigned PW_DEF         = 2;
  localparam int unsigned MW_DEF         = 5;
  localparam int unsigned PRICE_STEP_DEF = 5;
  localparam int unsigned STOCK_INIT_DEF = 2;
  localparam int unsigned SW_DEF         = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StVend,
    StRefund
  } state_e;

  // Product idx costs (idx+1) price steps.
  function automatic int unsigned price_of(int unsigned idx,
                                           int unsigned step = PRICE_STEP_DEF);
    return (idx + 1) * step;
  endfunction

endpackage

// File: rtl/vu_multi_if.sv
// Front-end / back-end signal bundle of the vending unit.
interface vu_multi_if #(
  parameter int unsigned PW = 2,
  parameter int unsigned MW = 5
) ();

  logic          sel_valid;
  logic [PW-1:0] sel;
  logic          coin_valid;
  logic [MW-1:0] coin_val;
  logic          cancel;
  logic          vend;
  logic [PW-1:0] vend_id;
  logic [MW-1:0] change;
  logic          change_valid;
  logic          coin_reject;
  logic          sold_out;
  logic          busy;
  logic [MW-1:0] credit;

  modport master (
    output sel_valid, sel, coin_valid, coin_val, cancel,
    input  vend, vend_id, change, change_valid, coin_reject, sold_out, busy, credit
  );

  modport slave (
    input  sel_valid, sel, coin_valid, coin_val, cancel,
    output vend, vend_id, change, change_valid, coin_reject, sold_out, busy, credit
  );

endinterface

// File: rtl/vu_stock.sv
// Per-product stock counters, reloaded to STOCK_INIT on reset and decremented on a vend.
module vu_stock
  import vu_pkg::*;
#(
  parameter int unsigned NPROD      = NPROD_DEF,
  parameter int unsigned PW         = PW_DEF,
  parameter int unsigned SW         = SW_DEF,
  parameter int unsigned STOCK_INIT = STOCK_INIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec,
  input  logic [PW-1:0]    dec_idx,
  output logic [NPROD-1:0] empty
);

  logic [SW-1:0] cnt_q [NPROD];
  logic [SW-1:0] cnt_d [NPROD];

  always_comb begin
    for (int i = 0; i < NPROD; i++) begin
      cnt_d[i] = cnt_q[i];
      // Saturate at zero so a stray strobe can never wrap the counter.
      if (dec && (dec_idx == PW'(i)) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPROD; i++) begin
        cnt_q[i] <= SW'(STOCK_INIT);
      end
    end else begin
      for (int i = 0; i < NPROD; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPROD; i++) begin
      empty[i] = (cnt_q[i] == '0);
    end
  end

endmodule

// File: rtl/vu_multi.sv
// Multi-product vending unit: selection, coin accumulation, vend with change or refund.
module vu_multi
  import vu_pkg::*;
#(
  parameter int unsigned NPROD      = NPROD_DEF,
  parameter int unsigned PW         = PW_DEF,
  parameter int unsigned MW         = MW_DEF,
  parameter int unsigned PRICE_STEP = PRICE_STEP_DEF,
  parameter int unsigned STOCK_INIT = STOCK_INIT_DEF,
  parameter int unsigned SW         = SW_DEF
) (
  input logic       clk,
  input logic       rst,
  vu_multi_if.slave bus
);

  state_e        state_q, state_d;
  logic [MW-1:0] credit_q, credit_d;
  logic [MW-1:0] cost_q, cost_d;
  logic [PW-1:0] sel_q, sel_d;

  logic          vend_q, vend_d;
  logic [PW-1:0] vend_id_q, vend_id_d;
  logic [MW-1:0] change_q, change_d;
  logic          change_valid_q, change_valid_d;
  logic          coin_reject_q, coin_reject_d;
  logic          sold_out_q, sold_out_d;
  logic          busy_q, busy_d;

  logic [MW:0]      sum;
  logic             stock_dec;
  logic [NPROD-1:0] stock_empty;

  vu_stock #(
    .NPROD      (NPROD),
    .PW         (PW),
    .SW         (SW),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .clk     (clk),
    .rst     (rst),
    .dec     (stock_dec),
    .dec_idx (sel_q),
    .empty   (stock_empty)
  );

  // One extra bit catches a coin that would overflow the credit register.
  assign sum = {1'b0, credit_q} + {1'b0, bus.coin_val};

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    cost_d         = cost_q;
    sel_d          = sel_q;
    vend_d         = 1'b0;
    vend_id_d      = '0;
    change_d       = '0;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    sold_out_d     = 1'b0;
    busy_d         = (state_q != StIdle);
    stock_dec      = 1'b0;

    unique case (state_q)
      StIdle: begin
        coin_reject_d = bus.coin_valid;
        if (bus.sel_valid && (32'(bus.sel) < NPROD)) begin
          if (stock_empty[bus.sel]) begin
            sold_out_d = 1'b1;
          end else begin
            sel_d    = bus.sel;
            cost_d   = MW'(price_of(32'(bus.sel), PRICE_STEP));
            credit_d = '0;
            state_d  = StCollect;
          end
        end
      end
      StCollect: begin
        if (bus.cancel) begin
          coin_reject_d = bus.coin_valid;
          state_d       = StRefund;
        end else if (bus.coin_valid) begin
          if (sum[MW]) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = sum[MW-1:0];
            if (sum[MW-1:0] >= cost_q) begin
              state_d = StVend;
            end
          end
        end
      end
      StVend: begin
        vend_d         = 1'b1;
        vend_id_d      = sel_q;
        change_d       = credit_q - cost_q;
        change_valid_d = 1'b1;
        coin_reject_d  = bus.coin_valid;
        stock_dec      = 1'b1;
        credit_d       = '0;
        state_d        = StIdle;
      end
      StRefund: begin
        change_d       = credit_q;
        change_valid_d = 1'b1;
        coin_reject_d  = bus.coin_valid;
        credit_d       = '0;
        state_d        = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      cost_q         <= '0;
      sel_q          <= '0;
      vend_q         <= 1'b0;
      vend_id_q      <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sold_out_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      cost_q         <= cost_d;
      sel_q          <= sel_d;
      vend_q         <= vend_d;
      vend_id_q      <= vend_id_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      sold_out_q     <= sold_out_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.vend         = vend_q;
  assign bus.vend_id      = vend_id_q;
  assign bus.change       = change_q;
  assign bus.change_valid = change_valid_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.busy         = busy_q;
  assign bus.credit       = credit_q;

endmodule

// File: tb/tb_vu_multi.sv
// Scoreboard bench for vu_multi: stimulus queues expected output events, a monitor checks them.
module tb_vu_multi;

  typedef struct packed {
    logic       vend;
    logic [1:0] id;
    logic       cv;
    logic [4:0] ch;
    logic       rej;
    logic       so;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vu_multi_if #(.PW(2), .MW(5)) bus ();

  vu_multi #(
    .NPROD      (4),
    .PW         (2),
    .MW         (5),
    .PRICE_STEP (5),
    .STOCK_INIT (2),
    .SW         (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic v, input logic [1:0] id, input logic cv,
                      input logic [4:0] ch, input logic rej, input logic so);
    ev_t e;
    e.vend = v; e.id = id; e.cv = cv; e.ch = ch; e.rej = rej; e.so = so;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic sv, input logic [1:0] s, input logic cv,
                      input logic [4:0] c, input logic can);
    bus.sel_valid  = sv;
    bus.sel        = s;
    bus.coin_valid = cv;
    bus.coin_val   = c;
    bus.cancel     = can;
    @(posedge clk);
    #1;
    bus.sel_valid  = 1'b0;
    bus.sel        = '0;
    bus.coin_valid = 1'b0;
    bus.coin_val   = '0;
    bus.cancel     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Any output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst && (bus.vend || bus.change_valid || bus.coin_reject || bus.sold_out)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual vend=%0d cv=%0d rej=%0d so=%0d required none",
                 bus.vend, bus.change_valid, bus.coin_reject, bus.sold_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_vend", int'(bus.vend), int'(mon_e.vend));
        chk("ev_change_valid", int'(bus.change_valid), int'(mon_e.cv));
        chk("ev_coin_reject", int'(bus.coin_reject), int'(mon_e.rej));
        chk("ev_sold_out", int'(bus.sold_out), int'(mon_e.so));
        if (mon_e.vend) chk("ev_vend_id", int'(bus.vend_id), int'(mon_e.id));
        if (mon_e.cv) chk("ev_change", int'(bus.change), int'(mon_e.ch));
      end
    end
  end

  initial begin
    bus.sel_valid  = 1'b0;
    bus.sel        = '0;
    bus.coin_valid = 1'b0;
    bus.coin_val   = '0;
    bus.cancel     = 1'b0;
    rst            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vend", int'(bus.vend), 0);
    chk("rst_change_valid", int'(bus.change_valid), 0);
    chk("rst_coin_reject", int'(bus.coin_reject), 0);
    chk("rst_sold_out", int'(bus.sold_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_change", int'(bus.change), 0);
    chk("rst_vend_id", int'(bus.vend_id), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    // Consume one unit of product 0 before the mid-run reset.
    step(1'b1, 2'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'd5, 1'b0);
    push(1'b1, 2'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(3);

    // Test 1: abort a purchase in progress with reset.
    step(1'b1, 2'd2, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'd5, 1'b0);
    chk("t1_credit_before_rst", int'(bus.credit), 5);
    #3 rst = 1'b0;
    #2;
    chk("t1_busy", int'(bus.busy), 0);
    chk("t1_credit", int'(bus.credit), 0);
    chk("t1_vend", int'(bus.vend), 0);
    chk("t1_change_valid", int'(bus.change_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    // Test 2: exact payment, then busy timing.
    step(1'b1, 2'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'd5, 1'b0);
    push(1'b1, 2'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(1);
    chk("t2_busy_during_vend", int'(bus.busy), 1);
    chk("t2_vend", int'(bus.vend), 1);
    idle(1);
    chk("t2_busy_after", int'(bus.busy), 0);
    idle(1);

    // Test 3: two coins with change.
    step(1'b1, 2'd2, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'd10, 1'b0);
    chk("t3_credit_10", int'(bus.credit), 10);
    step(1'b0, 2'd0, 1'b1, 5'd10, 1'b0);
    chk("t3_credit_20", int'(bus.credit), 20);
    push(1'b1, 2'd2, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(3);

    // Test 4: cancel with a simultaneous coin.
    step(1'b1, 2'd3, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'd10, 1'b0);
    chk("t4_credit_10", int'(bus.credit), 10);
    step(1'b0, 2'd0, 1'b1, 5'd5, 1'b1);
    push(1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    push(1'b0, 2'd0, 1'b1, 5'd10, 1'b0, 1'b0);
    idle(3);

    // Refund with zero credit still pulses change_valid.
    step(1'b1, 2'd2, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 5'd0, 1'b1);
    push(1'b0, 2'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(3);

    // Test 5: exhaust product 1, then sold-out.
    repeat (2) begin
      step(1'b1, 2'd1, 1'b0, 5'd0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 5'd10, 1'b0);
      push(1'b1, 2'd1, 1'b1, 5'd0, 1'b0, 1'b0);
      idle(3);
    end
    step(1'b1, 2'd1, 1'b0, 5'd0, 1'b0);
    push(1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("t5_busy_soldout", int'(bus.busy), 0);
    idle(1);
    chk("t5_busy_soldout_late", int'(bus.busy), 0);
    step(1'b1, 2'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'd5, 1'b0);
    push(1'b1, 2'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(3);
    // Product 0 bought twice since reset: now empty.
    step(1'b1, 2'd0, 1'b0, 5'd0, 1'b0);
    push(1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(2);

    // Test 6: overflow rejection, then completion.
    step(1'b1, 2'd3, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'd10, 1'b0);
    step(1'b0, 2'd0, 1'b1, 5'd5, 1'b0);
    chk("t6_credit_15", int'(bus.credit), 15);
    step(1'b0, 2'd0, 1'b1, 5'd20, 1'b0);
    push(1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("t6_credit_held", int'(bus.credit), 15);
    step(1'b0, 2'd0, 1'b1, 5'd5, 1'b0);
    push(1'b1, 2'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 2'd0, 1'b1, 5'd5, 1'b0);
    push(1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("t6_idle_credit", int'(bus.credit), 0);
    idle(4);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vu_multi.md
Name: vu_multi

Overview:
Parametrised multi-product vending unit and the next generation of the single-shot vending FSM. It takes a product selection, accumulates coins over several cycles, and then either vends with change or refunds on cancel. It tracks per-product stock, rejects coins that would overflow the credit register, and signals sold-out. It sits between the coin/keypad front end and the dispenser/change-return back end.

Parameters:
NPROD, 4, number of products; product i costs (i+1)*PRICE_STEP
PW, 2, selection width, ceil(log2(NPROD))
MW, 5, money width for coin value, credit, cost and change
PRICE_STEP, 5, price increment per product index
STOCK_INIT, 2, units loaded per product at reset
SW, 4, stock counter width (STOCK_INIT < 2^SW)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
sel_valid  in  1  selection strobe, sampled only in IDLE
sel  in  PW  product index
coin_valid  in  1  coin strobe, one coin per asserted cycle
coin_val  in  MW  coin value
cancel  in  1  abort purchase and request refund
vend  out  1  one-cycle dispense pulse
vend_id  out  PW  product dispensed; valid when vend=1
change  out  MW  amount returned; valid when change_valid=1
change_valid  out  1  one-cycle pulse on vend or refund
coin_reject  out  1  one-cycle pulse: coin returned unaccepted
sold_out  out  1  one-cycle pulse: selected product has zero stock
busy  out  1  high in any state other than IDLE
credit  out  MW  current accumulated credit

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0.
  - Credit and latched cost/selection are 0.
  - Every stock counter is loaded with STOCK_INIT.
- All outputs are registered.
- States: IDLE, COLLECT, VEND, REFUND.
- IDLE, when sel_valid=1:
  - sel >= NPROD: ignored.
  - stock[sel]==0: sold_out=1 for one cycle; remain in IDLE.
  - Otherwise: latch sel, cost=(sel+1)*PRICE_STEP, credit=0; go to COLLECT next cycle.
  - A coin_valid in IDLE produces coin_reject=1. Credit is unchanged.
- COLLECT, priority order per cycle: cancel, then coin.
  - cancel=1: go to REFUND. A coin in the same cycle is rejected (coin_reject=1).
  - coin_valid=1 and credit+coin_val > 2^MW-1 (computed at MW+1 bits): coin_reject=1; credit unchanged.
  - coin_valid=1 with no overflow: credit <= credit+coin_val.
  - If the new credit >= cost, go to VEND.
  - sel_valid is ignored in COLLECT.
- VEND, one cycle, entered on the edge after the completing coin:
  - vend=1, vend_id=latched sel.
  - change=credit-cost, change_valid=1.
  - stock[sel] decrements by 1; credit clears; next state IDLE.
  - Coins this cycle are rejected.
- REFUND, one cycle:
  - change=credit, change_valid=1, vend=0; credit clears; next state IDLE.
  - A refund with credit=0 still pulses change_valid with change=0.
- Latency:
  - Completing coin at edge k gives vend at edge k+1.
  - cancel at edge k gives refund at edge k+1.
  - busy drops at edge k+2.
- Stock never decrements below 0, since a product with zero stock cannot be selected.
- Mid-operation reset aborts with no vend and no refund. Credit is lost and stock reloads.

Decomposition:
- Package vu_pkg holds:
  - the state enum (IDLE, COLLECT, VEND, REFUND);
  - the price function price_of(idx) = (idx+1)*PRICE_STEP;
  - the default parameter constants.
- One sub-module, vu_stock: NPROD x SW counters with async-low reset to STOCK_INIT, a dec strobe with index, and a per-product empty flag.

Test Plan:
(NPROD=4, MW=5, PRICE_STEP=5, STOCK_INIT=2)
1. Assert rst=0 mid-run, then release -> all outputs 0, busy=0, credit=0; product 0 can be bought twice afterwards.
2. sel=0, then coin 5 -> next cycle vend=1, vend_id=0, change=0, change_valid=1; busy=0 one cycle later.
3. sel=2 (cost 15), coins 10 then 10 -> credit 10 then 20; vend_id=2, change=5.
4. sel=3 (cost 20), coin 10, then cancel together with a coin 5 -> coin_reject=1; change=10, change_valid=1, vend=0.
5. Buy product 1 twice successfully, then sel=1 -> sold_out=1, busy stays 0. sel=0 still succeeds.
6. sel=3, coins 10, 5 (credit 15), coin 20 -> coin_reject=1, credit stays 15; coin 5 -> vend_id=3, change=0. Also check: a coin in IDLE gives coin_reject=1.
